// File: rtl/joy_db15_tx.sv
// DB15 joystick adapter emulation: two-player 165-style shift chain driven by the receiver's JOY_LOAD/JOY_CLK.
// Optional build macro JOY_DB15_WDOG_EN adds a no-LOAD watchdog that returns the chain to idle.
module joy_db15_tx #(
   parameter int NBITS       = 16,
   parameter int SYNC_STAGES = 2
`ifdef JOY_DB15_WDOG_EN
   , parameter logic [23:0] WDOG_CYCLES = 24'd4800000
`endif
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] joystick1,
   input  logic [15:0] joystick2,
   input  logic        joy_clk,
   input  logic        joy_load,
   output logic        joy_data,
   output logic        busy,
   output logic        frame_done,
   output logic [5:0]  bit_cnt
);

   localparam logic [5:0] FRAME_BITS = 6'(2 * NBITS);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

   state_t                 r_state;
   logic [SYNC_STAGES-1:0] r_clk_sync, r_load_sync;
   logic                   r_clk_d, r_load_d;
   logic [31:0]            r_shreg;
   logic [5:0]             r_bit_cnt;
   logic                   r_busy, r_frame_done;

   logic        w_clk_s, w_load_s, w_clk_rise, w_load_fall, w_shift_en, w_wdog_fire;
   logic [31:0] w_img;

   assign w_clk_s     = r_clk_sync[SYNC_STAGES-1];
   assign w_load_s    = r_load_sync[SYNC_STAGES-1];
   assign w_clk_rise  = w_clk_s & ~r_clk_d;
   assign w_load_fall = ~w_load_s & r_load_d;
   // A clock edge only counts while load is released
   assign w_shift_en  = w_clk_rise & w_load_s;

   // Left-justified inverted image, unused tail bits read as released buttons
   always_comb begin
      w_img = '1;
      for (int i = 0; i < NBITS; i++) begin
         w_img[31-i]       = ~joystick1[NBITS-1-i];
         w_img[31-NBITS-i] = ~joystick2[NBITS-1-i];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_clk_sync  <= '1;
         r_load_sync <= '1;
         r_clk_d     <= 1'b1;
         r_load_d    <= 1'b1;
      end else begin
         r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], joy_clk};
         r_load_sync <= {r_load_sync[SYNC_STAGES-2:0], joy_load};
         r_clk_d     <= w_clk_s;
         r_load_d    <= w_load_s;
      end
   end

`ifdef JOY_DB15_WDOG_EN
   logic [23:0] r_wdog;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_wdog <= '0;
      else if (w_load_fall)
         r_wdog <= '0;
      else if (r_wdog != '1)
         r_wdog <= r_wdog + 24'd1;
   end

   assign w_wdog_fire = (r_wdog >= WDOG_CYCLES);
`else
   assign w_wdog_fire = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_shreg      <= '1;
         r_bit_cnt    <= '0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         // Load beats everything, including a coincident clock edge
         if (w_load_fall) begin
            r_state   <= S_LOAD;
            r_shreg   <= w_img;
            r_bit_cnt <= '0;
            r_busy    <= 1'b1;
         end else if (w_wdog_fire) begin
            r_state   <= S_IDLE;
            r_shreg   <= '1;
            r_bit_cnt <= '0;
            r_busy    <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: ;
               S_LOAD: begin
                  if (!w_load_s)
                     r_shreg <= w_img;
                  else
                     r_state <= S_SHIFT;
               end
               S_SHIFT: begin
                  if (w_shift_en) begin
                     r_shreg   <= {r_shreg[30:0], 1'b1};
                     r_bit_cnt <= r_bit_cnt + 6'd1;
                     if (r_bit_cnt == FRAME_BITS - 6'd1) begin
                        r_state      <= S_DONE;
                        r_busy       <= 1'b0;
                        r_frame_done <= 1'b1;
                     end
                  end
               end
               S_DONE: begin
                  if (w_shift_en)
                     r_shreg <= {r_shreg[30:0], 1'b1};
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign joy_data   = r_shreg[31];
   assign busy       = r_busy;
   assign frame_done = r_frame_done;
   assign bit_cnt    = r_bit_cnt;

endmodule

// File: tb/tb_joy_db15_tx.sv
// Bench for joy_db15_tx: 16-bit and 12-bit instances share pins and are checked against a bit-stream model.
module tb_joy_db15_tx;

   logic        clk = 1'b0, reset = 1'b1, joy_clk = 1'b0, joy_load = 1'b1;
   logic [15:0] j1 = '0, j2 = '0;
   logic        d16, b16, fd16, d12, b12, fd12;
   logic [5:0]  c16, c12;
   int          errors = 0, checks = 0, nfd16 = 0, nfd12 = 0;

   localparam int WDOG_WAIT = 450;

   joy_db15_tx #(.NBITS(16), .SYNC_STAGES(2)
`ifdef JOY_DB15_WDOG_EN
      , .WDOG_CYCLES(24'd400)
`endif
   ) u16 (
      .clk(clk), .reset(reset), .joystick1(j1), .joystick2(j2), .joy_clk(joy_clk),
      .joy_load(joy_load), .joy_data(d16), .busy(b16), .frame_done(fd16), .bit_cnt(c16));

   joy_db15_tx #(.NBITS(12), .SYNC_STAGES(2)
`ifdef JOY_DB15_WDOG_EN
      , .WDOG_CYCLES(24'd400)
`endif
   ) u12 (
      .clk(clk), .reset(reset), .joystick1(j1), .joystick2(j2), .joy_clk(joy_clk),
      .joy_load(joy_load), .joy_data(d12), .busy(b12), .frame_done(fd12), .bit_cnt(c12));

   always #10 clk = ~clk;

   always @(posedge clk) begin
      if (fd16 === 1'b1) nfd16++;
      if (fd12 === 1'b1) nfd12++;
   end

   // Serial bit k of a frame: P1 MSB-first, then P2, then released (1)
   function automatic logic exp_bit(input logic [15:0] a, input logic [15:0] b, input int n, input int k);
      if (k < n)          return ~a[n-1-k];
      else if (k < 2 * n) return ~b[2*n-1-k];
      else                return 1'b1;
   endfunction

   function automatic int exp_cnt(input int n, input int k);
      return (k < 2 * n) ? k : 2 * n;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_load();
      joy_load = 1'b0; tick(4);
      joy_load = 1'b1; tick(4);
   endtask

   task automatic rise();
      joy_clk = 1'b1; tick(4);
      joy_clk = 1'b0; tick(4);
   endtask

   task automatic check_frame(input string nm, input logic [15:0] a, input logic [15:0] b,
                              input int nr, input bit scramble);
      for (int k = 0; k <= nr; k++) begin
         checks++;
         if (d16 !== exp_bit(a, b, 16, k)) begin
            errors++; $display("FAIL %s n16 bit%0d joy_data=%b want %b", nm, k, d16, exp_bit(a, b, 16, k));
         end
         checks++;
         if (c16 !== 6'(exp_cnt(16, k))) begin
            errors++; $display("FAIL %s n16 bit%0d bit_cnt=%0d want %0d", nm, k, c16, exp_cnt(16, k));
         end
         checks++;
         if (b16 !== 1'(k < 32)) begin
            errors++; $display("FAIL %s n16 bit%0d busy=%b want %b", nm, k, b16, 1'(k < 32));
         end
         checks++;
         if (d12 !== exp_bit(a, b, 12, k)) begin
            errors++; $display("FAIL %s n12 bit%0d joy_data=%b want %b", nm, k, d12, exp_bit(a, b, 12, k));
         end
         checks++;
         if (c12 !== 6'(exp_cnt(12, k))) begin
            errors++; $display("FAIL %s n12 bit%0d bit_cnt=%0d want %0d", nm, k, c12, exp_cnt(12, k));
         end
         checks++;
         if (b12 !== 1'(k < 24)) begin
            errors++; $display("FAIL %s n12 bit%0d busy=%b want %b", nm, k, b12, 1'(k < 24));
         end
         if (k < nr) begin
            if (scramble) begin j1 = 16'($urandom); j2 = 16'($urandom); end
            rise();
         end
      end
   endtask

   task automatic check_done_counts(input string nm, input int w16, input int w12);
      checks++;
      if (nfd16 != w16) begin errors++; $display("FAIL %s n16 frame_done count=%0d want %0d", nm, nfd16, w16); end
      checks++;
      if (nfd12 != w12) begin errors++; $display("FAIL %s n12 frame_done count=%0d want %0d", nm, nfd12, w12); end
   endtask

   task automatic test_reset();
      reset = 1'b1; tick(3);
      reset = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         tick(1);
         checks++;
         if (d16 !== 1'b1 || b16 !== 1'b0 || c16 !== 6'd0 || fd16 !== 1'b0 ||
             d12 !== 1'b1 || b12 !== 1'b0 || c12 !== 6'd0 || fd12 !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle cyc%0d got d=%b%b busy=%b%b cnt=%0d/%0d fd=%b%b want d=11 busy=00 cnt=0/0 fd=00",
                     i, d16, d12, b16, b12, c16, c12, fd16, fd12);
         end
      end
   endtask

   task automatic test_frame16();
      logic [15:0] a = 16'h0001, b = 16'h8000;
      j1 = a; j2 = b; nfd16 = 0; nfd12 = 0;
      joy_load = 1'b0; tick(4);
      checks++;
      if (b16 !== 1'b1 || c16 !== 6'd0) begin
         errors++; $display("FAIL load_state busy=%b cnt=%0d want busy=1 cnt=0", b16, c16);
      end
      joy_load = 1'b1; tick(4);
      check_frame("frame16", a, b, 32, 1'b0);
      check_done_counts("frame16", 1, 1);
   endtask

   task automatic test_frame12();
      logic [15:0] a = 16'hFFFF, b = 16'h0000;
      j1 = a; j2 = b; nfd16 = 0; nfd12 = 0;
      do_load();
      check_frame("frame12", a, b, 30, 1'b0);
      check_done_counts("frame12", 0, 1);
   endtask

   task automatic test_latency();
      logic [15:0] a = 16'h7FFF, b = 16'h1234;
      j1 = a; j2 = b;
      do_load();
      joy_clk = 1'b1;
      for (int e = 1; e <= 3; e++) begin
         tick(1);
         checks++;
         if (d16 !== exp_bit(a, b, 16, (e == 3) ? 1 : 0)) begin
            errors++; $display("FAIL latency edge%0d joy_data=%b want %b", e, d16, exp_bit(a, b, 16, (e == 3) ? 1 : 0));
         end
      end
      joy_clk = 1'b0; tick(4);
   endtask

   task automatic test_abort();
      logic [15:0] a, b;
      a = 16'($urandom); b = 16'($urandom);
      j1 = a; j2 = b; nfd16 = 0; nfd12 = 0;
      do_load();
      check_frame("abort_pre", a, b, 10, 1'b0);
      a = 16'h0002; j1 = a;
      do_load();
      check_frame("abort_post", a, b, 32, 1'b0);
      check_done_counts("abort", 1, 1);
   endtask

   task automatic test_coincident();
      logic [15:0] a, b;
      a = 16'($urandom); b = 16'($urandom);
      j1 = a; j2 = b;
      do_load();
      for (int i = 0; i < 5; i++) rise();
      a = ~a; b = 16'($urandom); j1 = a; j2 = b;
      joy_clk = 1'b1; joy_load = 1'b0; tick(4);
      checks++;
      if (c16 !== 6'd0 || b16 !== 1'b1 || d16 !== exp_bit(a, b, 16, 0)) begin
         errors++; $display("FAIL coincident cnt=%0d busy=%b d=%b want cnt=0 busy=1 d=%b", c16, b16, d16, exp_bit(a, b, 16, 0));
      end
      // a clock pulse while load is held low must not shift
      joy_clk = 1'b0; tick(4);
      joy_clk = 1'b1; tick(4);
      joy_clk = 1'b0; tick(4);
      checks++;
      if (c16 !== 6'd0 || c12 !== 6'd0) begin
         errors++; $display("FAIL clk_in_load cnt=%0d/%0d want 0/0", c16, c12);
      end
      joy_load = 1'b1; tick(4);
      check_frame("coincident", a, b, 32, 1'b0);
   endtask

   task automatic test_random();
      logic [15:0] a, b;
      int nr;
      for (int it = 0; it < 6; it++) begin
         a = 16'($urandom); b = 16'($urandom);
         nr = $urandom_range(0, 34);
         j1 = a; j2 = b;
         do_load();
         nfd16 = 0; nfd12 = 0;
         check_frame("random", a, b, nr, 1'b1);
         check_done_counts("random", (nr >= 32) ? 1 : 0, (nr >= 24) ? 1 : 0);
      end
   endtask

   task automatic test_reset_midframe();
      j1 = 16'($urandom); j2 = 16'($urandom);
      do_load();
      for (int i = 0; i < 7; i++) rise();
      @(negedge clk); #2;
      reset = 1'b1; #1;
      checks++;
      if (d16 !== 1'b1 || b16 !== 1'b0 || c16 !== 6'd0 || fd16 !== 1'b0 ||
          d12 !== 1'b1 || b12 !== 1'b0 || c12 !== 6'd0) begin
         errors++; $display("FAIL async_reset d=%b%b busy=%b%b cnt=%0d/%0d want d=11 busy=00 cnt=0/0",
                            d16, d12, b16, b12, c16, c12);
      end
      tick(2); reset = 1'b0; tick(4);
   endtask

   task automatic test_wdog();
      logic [15:0] a, b;
      a = 16'($urandom); b = 16'($urandom);
      j1 = a; j2 = b;
      do_load();
      check_frame("wdog_frame", a, b, 32, 1'b0);
      tick(WDOG_WAIT);
`ifdef JOY_DB15_WDOG_EN
      checks++;
      if (c16 !== 6'd0 || c12 !== 6'd0 || d16 !== 1'b1 || b16 !== 1'b0) begin
         errors++; $display("FAIL wdog_idle cnt=%0d/%0d d=%b busy=%b want cnt=0/0 d=1 busy=0", c16, c12, d16, b16);
      end
`else
      checks++;
      if (c16 !== 6'd32 || c12 !== 6'd24 || d16 !== 1'b1 || b16 !== 1'b0) begin
         errors++; $display("FAIL stay_done cnt=%0d/%0d d=%b busy=%b want cnt=32/24 d=1 busy=0", c16, c12, d16, b16);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_frame16();
      test_frame12();
      test_latency();
      test_abort();
      test_coincident();
      test_random();
      test_reset_midframe();
      test_wdog();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
